bcd_seg_display: RTL and testbench

//  Sequential binary-to-decimal 7-segment driver; parametrised successor to the

---
 rtl/pbs_disp_pkg.sv | 28 ++
 rtl/seg7_encode.sv | 20 ++
 rtl/bcd_seg_display.sv | 175 +++++++++++++++++
 tb/tb_bcd_seg_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbs_disp_pkg.sv
// Shared constants for the decimal 7-segment display path: segment codes and FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pbs_disp_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_encode.sv
// One BCD digit to an active-low 7-segment code, with optional blanking.
// Latency: combinational.
// Backpressure: none; codes above 9 also show blank.
module seg7_encode
    import pbs_disp_pkg::*;
(
    input  logic [3:0] bcd_dat,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup; blank wins over the digit value
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd_dat <= 4'd9)) begin
            seg = SEG_DIGIT[bcd_dat];
        end
    end

endmodule

// File: rtl/bcd_seg_display.sv
// Iterative double-dabble binary-to-decimal converter driving DIGITS 7-seg codes.
// Latency: accept edge, IN_W shift cycles, one encode cycle; out_valid pulses one cycle.
// Backpressure: in_ready is low while converting; in_valid is ignored then, nothing queued.
module bcd_seg_display
    import pbs_disp_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    output logic [7*DIGITS-1:0]   seg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    output logic                  overflow
);

    localparam int CW = $clog2(IN_W + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    // Reset display shows a single "0" in the ones position
    function automatic logic [SW-1:0] seg_reset_val();
        logic [SW-1:0] v;
        v = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v[7*k +: 7] = (k > 0 && BLANK_LZ != 0) ? SEG_BLANK : SEG_DIGIT[0];
        end
        return v;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_reset_val();

    state_t          state_q, state_d;
    logic [IN_W-1:0] shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic            overflow_q, overflow_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic [BW-1:0]   adj;
    logic [DIGITS-1:0] blank;
    logic            higher_zero;
    logic [SW-1:0]   seg_enc;

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one SHIFT cycle per input bit, then a single ENCODE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = ENCODE;
            ENCODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Add-3 correction on every scratch digit that is 5 or more
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: digit k>0 blanks when it and every higher digit is zero
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_zero = higher_zero && (scratch_q[4*k +: 4] == 4'd0);
            blank[k]    = (BLANK_LZ != 0) && higher_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .bcd_dat (scratch_q[4*g +: 4]),
            .blank   (blank[g]),
            .seg     (seg_enc[7*g +: 7])
        );
    end

    // Datapath next values: load on accept, shift while converting, publish on encode
    always_comb begin
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        seg_d       = seg_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = in_value;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CW'(IN_W);
                end
            end
            SHIFT: begin
                // A 1 leaving the top digit means the value needs more digits than we have
                scratch_d = {adj[BW-2:0], shift_q[IN_W-1]};
                shift_d   = shift_q << 1;
                ovf_d     = ovf_q || adj[BW-1];
                cnt_d     = cnt_q - CW'(1);
            end
            ENCODE: begin
                overflow_d  = ovf_q;
                bcd_d       = ovf_q ? {DIGITS{4'h9}} : scratch_q;
                seg_d       = ovf_q ? {DIGITS{SEG_DASH}} : seg_enc;
                out_valid_d = 1'b1;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= '0;
            scratch_q   <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            seg_q       <= SEG_RST;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            seg_q       <= seg_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign seg       = seg_q;
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Bench for bcd_seg_display: three instances share stimulus (3 digits blanked,
// 3 digits unblanked, 2 digits blanked) and are checked against an arithmetic model.
// Edge count for latency includes the accept edge itself.
module tb_bcd_seg_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_value;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [20:0] seg0, seg1;
    logic [13:0] seg2;
    logic [11:0] bcd0, bcd1;
    logic [7:0]  bcd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_seg_display #(.IN_W(8), .DIGITS(3), .BLANK_LZ(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_value(in_value), .seg(seg0), .bcd(bcd0), .out_valid(ov0), .overflow(of0));
    bcd_seg_display #(.IN_W(8), .DIGITS(3), .BLANK_LZ(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_value(in_value), .seg(seg1), .bcd(bcd1), .out_valid(ov1), .overflow(of1));
    bcd_seg_display #(.IN_W(8), .DIGITS(2), .BLANK_LZ(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_value(in_value), .seg(seg2), .bcd(bcd2), .out_valid(ov2), .overflow(of2));

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic m_ovf(input int v, input int d);
        return v >= 10**d;
    endfunction

    function automatic logic [11:0] m_bcd(input int v, input int d);
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < d; k++)
            r[4*k +: 4] = m_ovf(v, d) ? 4'h9 : 4'((v / (10**k)) % 10);
        return r;
    endfunction

    function automatic logic [20:0] m_seg(input int v, input int d, input int blz);
        logic [20:0] r;
        r = '0;
        for (int k = 0; k < d; k++) begin
            if (m_ovf(v, d))                       r[7*k +: 7] = 7'b0111111;
            else if (blz != 0 && k > 0 && v < 10**k) r[7*k +: 7] = 7'h7F;
            else                                    r[7*k +: 7] = seg_of((v / (10**k)) % 10);
        end
        return r;
    endfunction

    // Present one value, wait for dut0's out_valid; lat = edges incl. accept edge
    task automatic do_conversion(input int v, output int lat, output bit to);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'(v);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!ov0 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n;
        to  = !ov0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [20:0] e0, e1, e2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        #23;
        e0 = m_seg(0, 3, 1); e1 = m_seg(0, 3, 0); e2 = m_seg(0, 2, 1);
        total++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin bad++; $display("FAIL reset_rdy got=%b want=111", {rdy0, rdy1, rdy2}); end
        total++; if ({ov0, ov1, ov2, of0, of1, of2} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {ov0, ov1, ov2, of0, of1, of2}); end
        total++; if ({bcd0, bcd1, bcd2} !== 32'h0) begin bad++; $display("FAIL reset_bcd got=%h want=0", {bcd0, bcd1, bcd2}); end
        total++; if (seg0 !== e0) begin bad++; $display("FAIL reset_seg0 got=%h want=%h", seg0, e0); end
        total++; if (seg1 !== e1) begin bad++; $display("FAIL reset_seg1 got=%h want=%h", seg1, e1); end
        total++; if (seg2 !== e2[13:0]) begin bad++; $display("FAIL reset_seg2 got=%h want=%h", seg2, e2[13:0]); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Convert a list of values and check every instance against the model
    task automatic test_values(input string name, input int vals[$]);
        int lat;
        bit to;
        logic [20:0] e2;
        foreach (vals[i]) begin
            int v;
            v = vals[i];
            total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL %s_ready v=%0d got=%b want=1", name, v, rdy0); end
            do_conversion(v, lat, to);
            total++; if (to || lat != 10) begin bad++; $display("FAIL %s_latency v=%0d got=%0d want=10", name, v, lat); end
            total++; if ({ov1, ov2} !== 2'b11) begin bad++; $display("FAIL %s_ovalid v=%0d got=%b want=11", name, v, {ov1, ov2}); end
            total++; if (bcd0 !== m_bcd(v, 3)) begin bad++; $display("FAIL %s_bcd0 v=%0d got=%h want=%h", name, v, bcd0, m_bcd(v, 3)); end
            total++; if (bcd1 !== m_bcd(v, 3)) begin bad++; $display("FAIL %s_bcd1 v=%0d got=%h want=%h", name, v, bcd1, m_bcd(v, 3)); end
            total++; if ({4'h0, bcd2} !== m_bcd(v, 2)) begin bad++; $display("FAIL %s_bcd2 v=%0d got=%h want=%h", name, v, bcd2, m_bcd(v, 2)); end
            total++; if (seg0 !== m_seg(v, 3, 1)) begin bad++; $display("FAIL %s_seg0 v=%0d got=%h want=%h", name, v, seg0, m_seg(v, 3, 1)); end
            total++; if (seg1 !== m_seg(v, 3, 0)) begin bad++; $display("FAIL %s_seg1 v=%0d got=%h want=%h", name, v, seg1, m_seg(v, 3, 0)); end
            e2 = m_seg(v, 2, 1);
            total++; if (seg2 !== e2[13:0]) begin bad++; $display("FAIL %s_seg2 v=%0d got=%h want=%h", name, v, seg2, e2[13:0]); end
            total++; if ({of0, of1, of2} !== {m_ovf(v, 3), m_ovf(v, 3), m_ovf(v, 2)}) begin
                bad++; $display("FAIL %s_ovf v=%0d got=%b want=%b", name, v, {of0, of1, of2}, {m_ovf(v, 3), m_ovf(v, 3), m_ovf(v, 2)});
            end
            @(negedge clk);
            total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL %s_pulse v=%0d got=%b want=0", name, v, ov0); end
        end
    endtask

    task automatic test_random();
        int vals[$];
        for (int i = 0; i < 20; i++) vals.push_back(int'($urandom_range(0, 255)));
        test_values("rand", vals);
    endtask

    // in_valid held high across two conversions
    task automatic test_back_to_back();
        int vals[2] = '{12, 34};
        int pulses;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'(vals[0]);
        for (int j = 0; j < 2; j++) begin
            pulses = 0;
            n = 0;
            while (pulses == 0 && n < 40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (ov0) pulses++;
                else begin
                    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready v=%0d edge=%0d got=%b want=0", vals[j], n, rdy0); end
                end
            end
            total++; if (n != 10) begin bad++; $display("FAIL b2b_latency v=%0d got=%0d want=10", vals[j], n); end
            total++; if (bcd0 !== m_bcd(vals[j], 3)) begin bad++; $display("FAIL b2b_bcd v=%0d got=%h want=%h", vals[j], bcd0, m_bcd(vals[j], 3)); end
            total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready v=%0d got=%b want=1", vals[j], rdy0); end
            if (j == 0) in_value = 8'(vals[1]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL b2b_extra_pulse got=%b want=0", ov0); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        int pulses;
        logic [20:0] e2;
        int pre[$] = '{150};
        test_values("pre", pre);   // leaves dut2 showing overflow
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        e2 = m_seg(0, 2, 1);
        total++; if ({bcd0, bcd2} !== 20'h0) begin bad++; $display("FAIL midrst_bcd got=%h want=0", {bcd0, bcd2}); end
        total++; if (seg0 !== m_seg(0, 3, 1) || seg2 !== e2[13:0]) begin bad++; $display("FAIL midrst_seg got=%h/%h want=%h/%h", seg0, seg2, m_seg(0, 3, 1), e2[13:0]); end
        total++; if ({of0, of2, ov0, rdy0} !== 4'b0001) begin bad++; $display("FAIL midrst_flags got=%b want=0001", {of0, of2, ov0, rdy0}); end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ov0 || ov2) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_pulse got=%0d want=0", pulses); end
        do_conversion(123, lat, to);
        total++; if (to || lat != 10) begin bad++; $display("FAIL midrst_latency got=%0d want=10", lat); end
        total++; if (bcd0 !== 12'h123 || seg0 !== m_seg(123, 3, 1)) begin bad++; $display("FAIL midrst_result got=%h/%h want=123/%h", bcd0, seg0, m_seg(123, 3, 1)); end
    endtask

    initial begin
        int dir[$];
        test_reset();
        dir = '{0, 255, 105, 7, 100, 99, 999 % 256, 10, 9, 1};
        test_values("dir", dir);
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
